// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, word type and range helper for the
// instruction-memory responder and its storage array.
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_t;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

    // True when a full 30-bit word index lies inside the array; there is no
    // wrap-around, so high address bits always count.
    function automatic logic idx_in_range(input logic [29:0] idx, input int depth);
        return {2'b00, idx} < 32'(depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x 32 single-clock instruction storage with one
// combinational-index read port and one synchronous write port. A write to
// the word being read in the same cycle is forwarded to the read port.
// Contents are not reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_idx_i,
    output word_t         rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  word_t         wr_data_i
);

    word_t mem_q [DEPTH_WORDS];

    // Program-load write; the caller only asserts wr_en_i for in-range indices.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Combinational read with write-first forwarding of a same-cycle write.
    always_comb begin
        rd_data_o = mem_q[rd_idx_i];
        if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: serves fetch-stage read requests from imem_array with a
// valid/ready handshake, WAIT_CYCLES of modelled latency, alignment/range
// fault reporting and a side write port for program loading.
// Optional feature: define IMEM_PREFETCH_EN to add a one-entry next-word
// prefetch buffer that answers a matching request with latency 1.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where rsp_valid && rsp_ready. Once raised,
// rsp_valid/rsp_instr/rsp_err stay stable until that transfer or a flush.
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES = 2,
    parameter word_t NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  word_t       req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output word_t       rsp_instr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  word_t       wr_addr,
    input  word_t       wr_data,
    output imem_state_t dbg_state_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    imem_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] idx_q;
    logic          fault_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    word_t         rsp_instr_q;

    logic          req_fault;
    logic          wr_ok;
    logic          pf_hit;
    word_t         pf_hit_data;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    word_t         rd_data;
    logic          unused_wr_lsbs;

    assign req_idx        = req_addr[AW+1:2];
    assign wr_idx         = wr_addr[AW+1:2];
    assign req_fault      = (req_addr[1:0] != 2'b00) || !idx_in_range(req_addr[31:2], DEPTH_WORDS);
    assign wr_ok          = wr_en && idx_in_range(wr_addr[31:2], DEPTH_WORDS);
    assign unused_wr_lsbs = ^wr_addr[1:0];

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk       (clk),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_ok),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data)
    );

`ifdef IMEM_PREFETCH_EN
    logic          pf_valid_q;
    logic [AW-1:0] pf_idx_q;
    word_t         pf_data_q;
    logic          pf_pend_q;
    logic [AW-1:0] pf_pend_idx_q;
    logic          rsp_done_ok;
    logic          hit_buf;
    logic          hit_pend;
    logic          pf_load;

    // A clean response handshake whose successor word exists schedules a load.
    assign rsp_done_ok = (state_q == IMEM_RESP) && rsp_ready && !flush && !rsp_err_q
                         && idx_in_range(30'(idx_q) + 30'd1, DEPTH_WORDS);
    // A same-cycle write to the buffered word makes the buffer stale: take the normal path.
    assign hit_buf     = pf_valid_q && !req_fault && (req_idx == pf_idx_q)
                         && !(wr_ok && (wr_idx == pf_idx_q));
    // The word being loaded this cycle is already on the read port.
    assign hit_pend    = pf_pend_q && !req_fault && (req_idx == pf_pend_idx_q);
    assign pf_hit      = (state_q == IMEM_IDLE) && req_valid && (hit_buf || hit_pend);
    assign pf_hit_data = hit_pend ? rd_data : pf_data_q;
    // With zero wait states a mismatching request needs the read port now, so the load yields.
    assign pf_load     = pf_pend_q && !((WAIT_CYCLES == 0) && req_valid && !hit_pend);

    // Read port: prefetch load or incoming request while idle, latched word otherwise.
    always_comb begin
        rd_idx = idx_q;
        if (state_q == IMEM_IDLE) begin
            rd_idx = pf_load ? pf_pend_idx_q : req_idx;
        end
    end

    // Prefetch buffer: filled in the idle cycle after a clean response, dropped on flush or overwrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_valid_q    <= 1'b0;
            pf_idx_q      <= '0;
            pf_data_q     <= '0;
            pf_pend_q     <= 1'b0;
            pf_pend_idx_q <= '0;
        end else if (flush) begin
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
        end else begin
            pf_pend_q     <= rsp_done_ok;
            pf_pend_idx_q <= idx_q + AW'(1);
            if (pf_load) begin
                pf_valid_q <= 1'b1;
                pf_idx_q   <= pf_pend_idx_q;
                pf_data_q  <= rd_data;
            end else if (wr_ok && (wr_idx == pf_idx_q)) begin
                pf_valid_q <= 1'b0;
            end
        end
    end
`else
    assign pf_hit      = 1'b0;
    assign pf_hit_data = '0;

    // Read port: incoming request while idle (zero-wait path), latched word otherwise.
    always_comb begin
        rd_idx = (state_q == IMEM_IDLE) ? req_idx : idx_q;
    end
`endif

    // Request/response FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IMEM_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            fault_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= IMEM_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IMEM_IDLE: begin
                    if (req_valid) begin
                        idx_q       <= req_idx;
                        fault_q     <= req_fault;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (pf_hit) begin
                            state_q     <= IMEM_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_instr_q <= pf_hit_data;
                            rsp_err_q   <= 1'b0;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q     <= IMEM_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_instr_q <= req_fault ? NOP_WORD : rd_data;
                            rsp_err_q   <= req_fault;
                        end else begin
                            state_q <= IMEM_WAIT;
                        end
                    end
                end
                IMEM_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= IMEM_RESP;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_instr_q <= fault_q ? NOP_WORD : rd_data;
                        rsp_err_q   <= fault_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                IMEM_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IMEM_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IMEM_IDLE;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_instr   = rsp_instr_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

endmodule
